// File: rtl/intr_prio.sv
// Prioritised interrupt controller: NSRC sources with enable, edge/level mode,
// polarity and 2-bit priority; threshold, claim register and software-set pending.
module intr_prio #(
  parameter int NSRC = 8,
  parameter int RV   = 16,
  parameter int SYNC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [3:0]      io_addr,
  input  logic            io_write,
  input  logic            io_read,
  input  logic [RV-1:0]   io_wdata,
  output logic [RV-1:0]   io_rdata,
  output logic            interrupt
);

  logic [NSRC-1:0]   pend_r, enable_r, mode_r, pol_r, prev_r;
  logic [1:0]        thresh_r;
  logic [2*NSRC-1:0] prio_r;

  logic [NSRC-1:0]   s_s, s2_s, edge_s, w1c_s, swset_s, mode_clr_s, claim_mask_s, pend_nxt_s;
  logic [2*NSRC-1:0] prio_nxt_s;
  logic [31:0]       prio_full_s;
  logic              wr_pend_s, wr_en_s, wr_mode_s, wr_pol_s, wr_thr_s, wr_swset_s;
  logic              wr_plo_s, wr_phi_s, claim_s, valid_s;
  logic [3:0]        win_id_s;
  logic [1:0]        best_s;

  assign wr_pend_s  = io_write && (io_addr == 4'd0);
  assign wr_en_s    = io_write && (io_addr == 4'd1);
  assign wr_mode_s  = io_write && (io_addr == 4'd2);
  assign wr_pol_s   = io_write && (io_addr == 4'd3);
  assign wr_thr_s   = io_write && (io_addr == 4'd4);
  assign wr_swset_s = io_write && (io_addr == 4'd6);
  assign wr_plo_s   = io_write && (io_addr == 4'd8);
  assign wr_phi_s   = io_write && (io_addr == 4'd9);
  assign claim_s    = io_read && (io_addr == 4'd5) && valid_s;

  assign s_s = irq_in ^ pol_r;

  if (SYNC != 0) begin : g_sync
    logic [NSRC-1:0] s1_r, s2_r;
    // Double-flop synchroniser for asynchronous source lines
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_r <= {NSRC{1'b0}};
        s2_r <= {NSRC{1'b0}};
      end else begin
        s1_r <= s_s;
        s2_r <= s1_r;
      end
    end
    assign s2_s = s2_r;
  end else begin : g_nosync
    assign s2_s = s_s;
  end

  // Edge-mode events; clear/set masks only ever touch edge-mode bits
  assign edge_s     = s2_s & ~prev_r & mode_r;
  assign w1c_s      = wr_pend_s ? (io_wdata[NSRC-1:0] & mode_r) : {NSRC{1'b0}};
  assign swset_s    = wr_swset_s ? (io_wdata[NSRC-1:0] & mode_r) : {NSRC{1'b0}};
  assign mode_clr_s = wr_mode_s ? (io_wdata[NSRC-1:0] & ~mode_r) : {NSRC{1'b0}};

  // Winner search: strict compare keeps the lowest index on ties, and
  // seeding with the threshold makes priority 0 ineligible
  always_comb begin
    valid_s  = 1'b0;
    win_id_s = 4'd0;
    best_s   = thresh_r;
    for (int i = 0; i < NSRC; i++) begin
      logic hit;
      hit      = pend_r[i] && enable_r[i] && (prio_r[2*i +: 2] > best_s);
      valid_s  = valid_s | hit;
      win_id_s = hit ? 4'(i) : win_id_s;
      best_s   = hit ? prio_r[2*i +: 2] : best_s;
    end
  end

  // Per-source next pending value and priority write merge
  always_comb begin
    claim_mask_s = {NSRC{1'b0}};
    prio_nxt_s   = prio_r;
    for (int i = 0; i < NSRC; i++) begin
      logic sel;
      claim_mask_s[i]      = claim_s && mode_r[i] && (win_id_s == 4'(i));
      sel                  = (i < 8) ? wr_plo_s : wr_phi_s;
      prio_nxt_s[2*i +: 2] = sel ? io_wdata[2*(i%8) +: 2] : prio_r[2*i +: 2];
    end
    pend_nxt_s = ((mode_r & (edge_s | swset_s | (pend_r & ~w1c_s & ~claim_mask_s)))
                 | (~mode_r & s2_s)) & ~mode_clr_s;
  end

  // Control/status registers and registered CPU request
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r    <= {NSRC{1'b0}};
      enable_r  <= {NSRC{1'b0}};
      mode_r    <= {NSRC{1'b0}};
      pol_r     <= {NSRC{1'b0}};
      prev_r    <= {NSRC{1'b0}};
      thresh_r  <= 2'b00;
      prio_r    <= {(2*NSRC){1'b0}};
      interrupt <= 1'b0;
    end else begin
      pend_r    <= pend_nxt_s;
      prev_r    <= s2_s;
      prio_r    <= prio_nxt_s;
      interrupt <= valid_s;
      if (wr_en_s)   enable_r <= io_wdata[NSRC-1:0];
      if (wr_mode_s) mode_r   <= io_wdata[NSRC-1:0];
      if (wr_pol_s)  pol_r    <= io_wdata[NSRC-1:0];
      if (wr_thr_s)  thresh_r <= io_wdata[1:0];
    end
  end

  // Register read mux, combinational from io_addr
  always_comb begin
    prio_full_s                = 32'h0000_0000;
    prio_full_s[2*NSRC-1:0]    = prio_r;
    io_rdata                   = {RV{1'b0}};
    case (io_addr)
      4'd0: io_rdata[NSRC-1:0] = pend_r;
      4'd1: io_rdata[NSRC-1:0] = enable_r;
      4'd2: io_rdata[NSRC-1:0] = mode_r;
      4'd3: io_rdata[NSRC-1:0] = pol_r;
      4'd4: io_rdata[1:0]      = thresh_r;
      4'd5: begin
        io_rdata[RV-1] = valid_s;
        io_rdata[3:0]  = win_id_s;
      end
      4'd8: io_rdata[15:0]     = prio_full_s[15:0];
      4'd9: io_rdata[15:0]     = prio_full_s[31:16];
      default: io_rdata        = {RV{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_intr_prio.sv
// Directed bench for intr_prio: expectations are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_intr_prio;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [3:0]  io_addr;
  logic        io_write, io_read;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        interrupt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  intr_prio #(.NSRC(8), .RV(16), .SYNC(1)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .io_addr(io_addr),
    .io_write(io_write), .io_read(io_read), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_v(input logic [15:0] obs);
    logic [15:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", t, obs, e);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e, input string tag);
    io_addr = a;
    expect_v(tag, e);
    #1;
    check_v(io_rdata);
  endtask

  task automatic chk_int(input logic e, input string tag);
    expect_v(tag, {15'h0000, e});
    check_v({15'h0000, interrupt});
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_addr  = a;
    io_wdata = d;
    io_write = 1'b1;
    tick();
    io_write = 1'b0;
  endtask

  task automatic claim();
    io_addr = 4'd5;
    io_read = 1'b1;
    tick();
    io_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = 8'h00; io_addr = 4'd0;
    io_write = 1'b0; io_read = 1'b0; io_wdata = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_int(1'b0, "reset_int");
    rd(4'd0, 16'h0000, "reset_pend");
    rd(4'd5, 16'h0000, "reset_claim");

    // src3 edge, prio 2, enabled; one-cycle pulse
    wr(4'd2, 16'h0008);
    wr(4'd1, 16'h0008);
    wr(4'd8, 16'h0080);
    wr(4'd4, 16'h0000);
    irq_in = 8'h08;
    tick();                       // edge N samples the pulse
    irq_in = 8'h00;
    tick();                       // N+1: s2 set
    rd(4'd0, 16'h0000, "lat_pend_n1");
    tick();                       // N+2: pending set
    rd(4'd0, 16'h0008, "lat_pend_n2");
    chk_int(1'b0, "lat_int_n2");
    tick();                       // N+3: interrupt
    chk_int(1'b1, "lat_int_n3");
    rd(4'd5, 16'h8003, "claim_src3");
    claim();
    rd(4'd0, 16'h0000, "claim_clears_pend3");
    chk_int(1'b1, "int_hold_after_claim");
    tick();
    chk_int(1'b0, "int_fall_after_claim");

    // src1 prio1, src5 prio3 both pending
    wr(4'd2, 16'h002A);
    wr(4'd1, 16'h002A);
    wr(4'd8, 16'h0C84);
    wr(4'd6, 16'h0022);
    rd(4'd0, 16'h0022, "pend_1_5");
    rd(4'd5, 16'h8005, "claim_highest");
    tick();
    chk_int(1'b1, "int_two_pending");
    wr(4'd8, 16'h0484);
    rd(4'd5, 16'h8001, "claim_tie_low_idx");
    wr(4'd4, 16'h0001);
    rd(4'd5, 16'h0000, "claim_thresh");
    tick();
    chk_int(1'b0, "int_thresh_fall");
    wr(4'd0, 16'h0022);
    wr(4'd4, 16'h0000);
    rd(4'd0, 16'h0000, "w1c_edge");

    // src2 level, active-low, held low
    wr(4'd1, 16'h002E);
    wr(4'd8, 16'h0494);
    wr(4'd3, 16'h0004);
    repeat (4) tick();
    rd(4'd0, 16'h0004, "level_pend");
    chk_int(1'b1, "level_int");
    rd(4'd5, 16'h8002, "claim_level");
    claim();
    rd(4'd0, 16'h0004, "level_claim_kept");
    wr(4'd0, 16'h0004);
    rd(4'd0, 16'h0004, "level_w1c_kept");
    irq_in = 8'h04;
    tick();
    tick();
    rd(4'd0, 16'h0004, "level_pend_2clk");
    tick();
    rd(4'd0, 16'h0000, "level_pend_3clk");
    tick();

    // src6 edge, prio1: SWSET then W1C racing a real edge
    wr(4'd2, 16'h006A);
    wr(4'd1, 16'h006E);
    wr(4'd8, 16'h1494);
    wr(4'd6, 16'h0040);
    rd(4'd0, 16'h0040, "swset_pend");
    tick();
    chk_int(1'b1, "swset_int");
    irq_in = 8'h44;
    tick();
    tick();
    wr(4'd0, 16'h0040);           // lands with the edge reaching pending
    rd(4'd0, 16'h0040, "edge_beats_w1c");
    wr(4'd0, 16'h0040);
    rd(4'd0, 16'h0000, "w1c_after_race");
    irq_in = 8'h04;

    // Out-of-range bits, unmapped addresses, priority 0
    wr(4'd1, 16'hFFFF);
    rd(4'd1, 16'h00FF, "enable_mask");
    rd(4'd7, 16'h0000, "addr7_zero");
    rd(4'd6, 16'h0000, "swset_reads0");
    wr(4'd9, 16'hFFFF);
    rd(4'd9, 16'h0000, "prio_hi_absent");
    wr(4'd8, 16'h0000);
    wr(4'd2, 16'h006B);
    wr(4'd6, 16'h0001);
    rd(4'd0, 16'h0001, "prio0_pend");
    tick();
    tick();
    chk_int(1'b0, "prio0_no_int");
    rd(4'd5, 16'h0000, "prio0_claim");

    // Reset mid-operation with a write strobe present
    wr(4'd8, 16'h0003);
    tick();
    chk_int(1'b1, "pre_reset_int");
    reset    = 1'b1;
    irq_in   = 8'h00;
    io_addr  = 4'd6;
    io_wdata = 16'h00FF;
    io_write = 1'b1;
    tick();
    reset    = 1'b0;
    io_write = 1'b0;
    chk_int(1'b0, "rst_int");
    rd(4'd0, 16'h0000, "rst_pend");
    rd(4'd1, 16'h0000, "rst_enable");
    rd(4'd2, 16'h0000, "rst_mode");
    rd(4'd3, 16'h0000, "rst_pol");
    rd(4'd4, 16'h0000, "rst_thresh");
    rd(4'd8, 16'h0000, "rst_prio");
    rd(4'd5, 16'h0000, "rst_claim");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
